// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction RAM and
// buffers returned words in a 2-entry FIFO for decode.
module fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
);

  typedef struct packed {
    logic [31:0]       word;
    logic [ADDR_W-1:0] pc;
  } ent_t;

  ent_t [1:0]        q;
  logic [1:0]        qv;
  ent_t              ent_in;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic              inflight, dead;
  logic              pop, push;
  logic [1:0]        used;

  assign pop    = qv[0] & inst_ready;
  // dead marks the response slot a redirect invalidated; it never pushes
  assign push   = inflight & ~dead & ~redirect;
  assign ent_in = '{word: imem_rdata, pc: req_pc};
  assign used   = {1'b0, qv[0]} + {1'b0, qv[1]} + {1'b0, inflight};

  // Credit rule: queued + in-flight words, less the one leaving now, must stay below 2.
  // pop implies qv[0], so the subtraction cannot underflow.
  assign imem_req  = rst_n & ~redirect & ((used - {1'b0, pop}) < 2'd2);
  assign imem_addr = fetch_pc;

  assign inst_valid = qv[0];
  assign inst       = q[0].word;
  assign inst_pc    = q[0].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      dead     <= 1'b0;
    end else begin
      inflight <= imem_req;
      dead     <= redirect & inflight;
      if (redirect)
        fetch_pc <= redirect_pc;
      else if (imem_req) begin
        fetch_pc <= fetch_pc + 1'b1;
        req_pc   <= fetch_pc;
      end
    end
  end

  // Shift-style FIFO: entry 0 is always the head shown to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      qv <= '0;
    end else if (redirect) begin
      qv <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (qv[0]) begin
            q[1]  <= ent_in;
            qv[1] <= 1'b1;
          end else begin
            q[0]  <= ent_in;
            qv[0] <= 1'b1;
          end
        end
        2'b01: begin
          q[0] <= q[1];
          qv   <= {1'b0, qv[1]};
        end
        2'b11: begin
          if (qv[1]) begin
            q[0] <= q[1];
            q[1] <= ent_in;
          end else begin
            q[0] <= ent_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus random ready/redirect traffic
// checked against a stream-level model (expected next pc, earliest valid cycle).
module tb_fetch_unit;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_ready = 1'b0;
  logic          imem_req, imem_req2;
  logic [AW-1:0] imem_addr, imem_addr2;
  logic [31:0]   imem_rdata, imem_rdata2;
  logic          inst_valid, inst_valid2;
  logic [31:0]   inst, inst2;
  logic [AW-1:0] inst_pc, inst_pc2;

  logic [31:0]   ram [0:(1<<AW)-1];
  logic          poison = 1'b0;

  int            total = 0, bad = 0, cyc = 0, vld_from = 2, mode = 0;
  logic [AW-1:0] exp_pc = '0;

  always #5 clk = ~clk;

  // RAM: data for the request seen at an edge is visible the following cycle
  always @(posedge clk) begin
    imem_rdata  <= poison ? 32'hDEADBEEF : ram[imem_addr];
    imem_rdata2 <= ram[imem_addr2];
  end

  fetch_unit #(.ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc));

  fetch_unit #(.ADDR_W(AW), .RESET_PC(12'hFFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect(1'b0), .redirect_pc(12'h000),
    .inst_valid(inst_valid2), .inst_ready(1'b1), .inst(inst2), .inst_pc(inst_pc2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sample mid-cycle, update the model, then advance to just after the next edge.
  task automatic tick();
    logic [AW-1:0] p2;
    @(negedge clk);
    chk("vld", inst_valid, 64'(cyc >= vld_from));
    if (redirect) chk("req_redir", imem_req, 64'd0);
    case (mode)
      1: begin
        if (cyc == 0) begin
          chk("req0", imem_req, 64'd1);
          chk("addr0", imem_addr, 64'd0);
        end
        if (cyc >= 2 && cyc <= 5) begin
          p2 = AW'(12'hFFE + cyc - 2);
          chk("vld2", inst_valid2, 64'd1);
          chk("pc2", inst_pc2, p2);
          chk("word2", inst2, ram[p2]);
        end
      end
      2: begin
        if (cyc >= 2 && cyc <= 11) chk("req_stall", imem_req, 64'd0);
        if (cyc == 12) chk("req_resume", imem_req, 64'd1);
      end
      3: if (cyc == 9) chk("redir_pc", inst_pc, 64'h100);
      4: if (cyc == 10) chk("redir2_pc", inst_pc, 64'h200);
      5: if (cyc == 2) chk("rst_word", inst, ram[0]);
      default: ;
    endcase
    if (inst_valid && inst_ready) begin
      chk("pc", inst_pc, exp_pc);
      chk("word", inst, ram[exp_pc]);
      exp_pc++;
    end
    if (redirect) begin
      exp_pc   = redirect_pc;
      vld_from = cyc + 3;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    redirect = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_req", imem_req, 64'd0);
    chk("rst_vld", inst_valid, 64'd0);
    chk("rst_inst", inst, 64'd0);
    chk("rst_pc", inst_pc, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    poison   = 1'b0;
    cyc      = 0;
    exp_pc   = '0;
    vld_from = 2;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h1000_0000 + i;

    // streaming from reset, plus wrap-around on the 0xFFE instance
    mode = 1; inst_ready = 1'b1;
    do_reset();
    repeat (8) tick();

    // decoder stall: queue fills to 2, requests stop, then resume in order
    mode = 2;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      inst_ready = (c < 2 || c >= 12);
      tick();
    end

    // single redirect
    mode = 3; inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      redirect = (c == 6); redirect_pc = 12'h100;
      tick();
    end
    redirect = 1'b0;

    // back-to-back redirects: last wins
    mode = 4;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      redirect    = (c == 6 || c == 7);
      redirect_pc = (c == 6) ? 12'h100 : 12'h200;
      tick();
    end
    redirect = 1'b0;

    // reset asserted mid-response while RAM returns garbage
    mode = 0;
    do_reset();
    tick(); tick();
    poison = 1'b1;
    tick();
    #2;
    mode = 5;
    do_reset();
    repeat (8) tick();

    // random ready / redirect traffic against the stream model
    mode = 0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = AW'($urandom);
      tick();
    end
    redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
